seq_scan_ctrl: RTL and testbench
================================

// Module: seq_scan_ctrl
// PURPOSE
//   Sequencer for the serial "1011" overlapping Mealy detector (ports clk/reset/x/z).
//   - Accepts parallel words over a valid/ready handshake.
//   - Clears the detector, then shifts each word into it MSB-first, one bit per clock.
//   - Counts detector z pulses and returns the per-word match count over a valid/ready handshake.
//   - Sits between a word-oriented producer and one detector instance; scan is word-local
//     (matches spanning two words are not counted).
// PARAMETERS
//   WIDTH  8                   bits per input word (>=4)
//   CW     $clog2(WIDTH+1)     width of match-count output
// PORTS
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   in_valid   in   1      producer has a word on in_data
//   in_data    in   WIDTH  word to scan, bit WIDTH-1 shifted first
//   in_ready   out  1      controller can accept a word (IDLE only)
//   det_clr    out  1      drives detector reset; one-cycle pulse before each scan
//   det_x      out  1      serial bit to detector x
//   det_z      in   1      detector z (Mealy, combinational on det_x and detector state)
//   out_valid  out  1      match count available
//   out_count  out  CW     number of z pulses seen while scanning the word
//   out_ready  in   1      consumer accepts out_count
//   busy       out  1      high in any state except IDLE
// BEHAVIOUR
//   Reset (async, any state) -> IDLE.
//     - Reset values: in_ready=1, det_clr=0, det_x=0, out_valid=0, out_count=0, busy=0.
//     - Shift register and bit counter are cleared.
//   IDLE: in_ready=1. On in_valid&&in_ready at edge T:
//     - capture in_data into the shift register;
//     - clear the match counter;
//     - go to CLR.
//   CLR (cycle T+1): det_clr=1, det_x=0, in_ready=0. Next state is SHIFT.
//   SHIFT (cycles T+2 .. T+WIDTH+1):
//     - det_x = shift-register MSB, driven from a flop, never combinational from in_data.
//     - Each edge: if det_z==1, match counter +1. Shift left by 1 and bit counter +1.
//     - After the WIDTH-th bit edge -> DONE.
//   DONE (from T+WIDTH+2):
//     - out_valid=1, out_count=match counter, det_x=0.
//     - out_count is held stable while out_valid && !out_ready.
//     - On out_valid&&out_ready -> IDLE. A new word can be accepted one cycle after the handshake.
//   Latency: input accept edge to out_valid = WIDTH+2 cycles. Throughput = one word per WIDTH+4 cycles.
//   det_z is ignored outside SHIFT, including during CLR and DONE.
//   Count never overflows: at most floor((WIDTH-1)/3) matches < 2^CW.
//   in_valid while busy: ignored; the producer must hold the word (in_ready=0).
//   in_data changing after the accept edge: no effect on the scan in progress.
//   Reset mid-SHIFT or mid-DONE:
//     - The pending result is discarded; out_valid drops immediately.
//     - The detector is cleared again by the CLR of the next word.
//   No state other than IDLE/CLR/SHIFT/DONE is reachable. Illegal encodings -> IDLE.
// TESTING (WIDTH=8, in each case out_ready=1 unless stated)
//   1. in_data=8'b1011_0110 (1,0,1,1,0,1,1,0)
//      -> out_count=2 (overlap at bits 0-3 and 3-6); out_valid exactly 10 cycles after accept.
//   2. in_data=8'b1011_1011 -> out_count=2.
//      in_data=8'h00 -> 0. in_data=8'b1010_1010 -> 0.
//   3. Word A=8'b0000_0101, then word B=8'b1000_0000
//      -> out_count=0 for both. Check det_clr pulse between the words; no cross-word match.
//   4. Backpressure: out_ready=0 for 5 cycles after out_valid.
//      -> out_valid and out_count held, in_ready=0, in_valid ignored.
//      Raise out_ready -> IDLE next cycle.
//   5. Assert reset at the 4th SHIFT cycle of 8'b1011_1011.
//      -> Outputs go to reset values immediately.
//      Next word 8'b0000_1011 -> out_count=1.
//   6. Back-to-back: in_valid held high with 4 different words
//      -> 4 results in order, each accept WIDTH+4 cycles apart.
//      det_x is only ever non-zero in SHIFT.

Source files
------------

// File: rtl/seq_scan_ctrl_if.sv
// Handshake and detector-side signal bundle for seq_scan_ctrl.
// Master is the producer/consumer/detector side; slave is the controller.
interface seq_scan_ctrl_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = $clog2(WIDTH + 1)
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             det_clr;
   logic             det_x;
   logic             det_z;
   logic             out_valid;
   logic [CW-1:0]    out_count;
   logic             out_ready;
   logic             busy;

   modport master (
      output in_valid, in_data, det_z, out_ready,
      input  in_ready, det_clr, det_x, out_valid, out_count, busy
   );

   modport slave (
      input  in_valid, in_data, det_z, out_ready,
      output in_ready, det_clr, det_x, out_valid, out_count, busy
   );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Word-to-serial sequencer for a "1011" Mealy detector: clears the detector,
// shifts each accepted word MSB-first and returns the per-word z-pulse count.
module seq_scan_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   seq_scan_ctrl_if.slave      bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned BW = $clog2(WIDTH);

   typedef enum logic [1:0] {ST_IDLE, ST_CLR, ST_SHIFT, ST_DONE} state_t;

   state_t           r_state,     w_state_nxt;
   logic [WIDTH-1:0] r_sr,        w_sr_nxt;
   logic [BW-1:0]    r_bit_cnt,   w_bit_cnt_nxt;
   logic [CW-1:0]    r_match_cnt, w_match_cnt_nxt;
   logic [CW-1:0]    r_out_count, w_out_count_nxt;
   logic             r_in_ready,  w_in_ready_nxt;
   logic             r_det_clr,   w_det_clr_nxt;
   logic             r_det_x,     w_det_x_nxt;
   logic             r_out_valid, w_out_valid_nxt;
   logic             r_busy,      w_busy_nxt;
   logic             w_accept;
   logic [CW-1:0]    w_match_inc;

   assign w_accept    = bus.in_valid && r_in_ready;
   assign w_match_inc = r_match_cnt + CW'(bus.det_z);

   // Next-state and next-output decode; det_z only matters while shifting.
   always_comb begin
      w_state_nxt     = r_state;
      w_sr_nxt        = r_sr;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_match_cnt_nxt = r_match_cnt;
      w_out_count_nxt = r_out_count;
      w_det_clr_nxt   = 1'b0;
      w_det_x_nxt     = 1'b0;
      w_out_valid_nxt = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_sr_nxt        = bus.in_data;
               w_match_cnt_nxt = '0;
               w_bit_cnt_nxt   = '0;
               w_det_clr_nxt   = 1'b1;
               w_state_nxt     = ST_CLR;
            end
         end
         ST_CLR: begin
            w_det_x_nxt = r_sr[WIDTH-1];
            w_sr_nxt    = {r_sr[WIDTH-2:0], 1'b0};
            w_state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            w_match_cnt_nxt = w_match_inc;
            w_bit_cnt_nxt   = r_bit_cnt + BW'(1);
            if (r_bit_cnt == BW'(WIDTH - 1)) begin
               w_out_valid_nxt = 1'b1;
               w_out_count_nxt = w_match_inc;
               w_state_nxt     = ST_DONE;
            end else begin
               w_det_x_nxt = r_sr[WIDTH-1];
               w_sr_nxt    = {r_sr[WIDTH-2:0], 1'b0};
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_out_valid_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // in_ready comes back one cycle after the result handshake
      w_in_ready_nxt = (r_state == ST_IDLE) && (w_state_nxt == ST_IDLE);
      w_busy_nxt     = (w_state_nxt != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_sr        <= '0;
         r_bit_cnt   <= '0;
         r_match_cnt <= '0;
         r_out_count <= '0;
         r_in_ready  <= 1'b1;
         r_det_clr   <= 1'b0;
         r_det_x     <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sr        <= w_sr_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_match_cnt <= w_match_cnt_nxt;
         r_out_count <= w_out_count_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_det_clr   <= w_det_clr_nxt;
         r_det_x     <= w_det_x_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.det_clr   = r_det_clr;
   assign bus.det_x     = r_det_x;
   assign bus.out_valid = r_out_valid;
   assign bus.out_count = r_out_count;
   assign bus.busy      = r_busy;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl with a behavioural overlapping "1011" Mealy detector.
module tb_seq_scan_ctrl;
   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   detx_viol = 0;

   seq_scan_ctrl_if #(.WIDTH(W)) bus ();

   seq_scan_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Detector model: S0 idle, S1 "1", S2 "10", S3 "101"
   typedef enum logic [1:0] {D0, D1, D2, D3} dst_t;
   dst_t d_st;
   logic det_rst;
   assign det_rst   = rst | bus.det_clr;
   assign bus.det_z = (d_st == D3) && bus.det_x;

   always @(posedge clk or posedge det_rst) begin
      if (det_rst) d_st <= D0;
      else begin
         case (d_st)
            D0:      d_st <= bus.det_x ? D1 : D0;
            D1:      d_st <= bus.det_x ? D1 : D2;
            D2:      d_st <= bus.det_x ? D3 : D0;
            default: d_st <= bus.det_x ? D1 : D2;
         endcase
      end
   end

   // det_x must stay low whenever the controller is not shifting
   always @(negedge clk) begin
      if (bus.det_x && (bus.det_clr || bus.out_valid || bus.in_ready || !bus.busy))
         detx_viol++;
   end

   typedef struct packed {
      logic [7:0] data;
      logic [3:0] exp_cnt;
   } vec_t;

   vec_t       vecs [9];
   logic [7:0] bw   [4];
   logic [3:0] be   [4];
   logic [3:0] got  [4];
   int         acc_cyc [4];
   int         na, nr;
   bit         will_acc, will_res;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic accept(input logic [7:0] d);
      int n;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      chk("accept_ready", 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      step();
      bus.in_valid = 1'b0;
      bus.in_data  = ~d;
   endtask

   // Full word with out_ready=1: CLR, WIDTH bits, result, handshake, ready gap
   task automatic run_word(input logic [7:0] d, input logic [3:0] exp_cnt);
      logic [7:0] bits;
      int         early;
      bits  = '0;
      early = 0;
      accept(d);
      chk("clr_pulse", 32'(bus.det_clr), 1);
      chk("clr_in_ready", 32'(bus.in_ready), 0);
      chk("clr_busy", 32'(bus.busy), 1);
      for (int k = 1; k <= 8; k++) begin
         step();
         bits[8-k] = bus.det_x;
         if (bus.out_valid !== 1'b0 || bus.det_clr !== 1'b0) early++;
      end
      chk("shift_no_valid", 32'(early), 0);
      step();
      chk("out_valid_latency", 32'(bus.out_valid), 1);
      chk("det_x_stream", 32'(bits), 32'(d));
      chk("out_count", 32'(bus.out_count), 32'(exp_cnt));
      step();
      chk("post_hs_valid", 32'(bus.out_valid), 0);
      chk("post_hs_busy", 32'(bus.busy), 0);
      chk("post_hs_gap", 32'(bus.in_ready), 0);
      step();
      chk("idle_ready", 32'(bus.in_ready), 1);
   endtask

   initial begin
      vecs[0] = '{8'b1011_0110, 4'd2};
      vecs[1] = '{8'b1011_1011, 4'd2};
      vecs[2] = '{8'h00,        4'd0};
      vecs[3] = '{8'b1010_1010, 4'd0};
      vecs[4] = '{8'b0000_0101, 4'd0};
      vecs[5] = '{8'b1000_0000, 4'd0};
      vecs[6] = '{8'b0000_1011, 4'd1};
      vecs[7] = '{8'hFF,        4'd0};
      vecs[8] = '{8'b0101_1011, 4'd2};
      bw[0] = 8'b1011_0110; be[0] = 4'd2;
      bw[1] = 8'b0000_1011; be[1] = 4'd1;
      bw[2] = 8'b1101_1011; be[2] = 4'd2;
      bw[3] = 8'b0110_1101; be[3] = 4'd1;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      repeat (2) step();
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_det_clr", 32'(bus.det_clr), 0);
      chk("rst_det_x", 32'(bus.det_x), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_count", 32'(bus.out_count), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 9; i++) run_word(vecs[i].data, vecs[i].exp_cnt);

      // Backpressure: result held, in_valid ignored while waiting
      bus.out_ready = 1'b0;
      accept(8'b1011_0110);
      repeat (9) step();
      chk("bp_valid_rise", 32'(bus.out_valid), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_valid", 32'(bus.out_valid), 1);
         chk("bp_hold_count", 32'(bus.out_count), 2);
         chk("bp_in_ready", 32'(bus.in_ready), 0);
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("bp_still_valid", 32'(bus.out_valid), 1);
      step();
      chk("bp_release_valid", 32'(bus.out_valid), 0);
      chk("bp_release_idle", 32'(bus.busy), 0);
      step();

      // Asynchronous reset during the 4th shift cycle
      accept(8'b1011_1011);
      repeat (4) step();
      chk("pre_rst_busy", 32'(bus.busy), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
      chk("mid_rst_det_x", 32'(bus.det_x), 0);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
      chk("mid_rst_out_count", 32'(bus.out_count), 0);
      chk("mid_rst_busy", 32'(bus.busy), 0);
      step();
      rst = 1'b0;
      step();
      run_word(8'b0000_1011, 4'd1);

      // Back-to-back words with in_valid held high
      na = 0;
      nr = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = bw[0];
      for (int c = 0; c < 100 && nr < 4; c++) begin
         will_acc = bus.in_valid && bus.in_ready;
         will_res = bus.out_valid && bus.out_ready;
         if (will_res) begin
            got[nr] = bus.out_count;
            nr++;
         end
         step();
         if (will_acc) begin
            acc_cyc[na] = cyc;
            na++;
            if (na < 4) bus.in_data = bw[na];
            else bus.in_valid = 1'b0;
         end
      end
      bus.in_valid = 1'b0;
      chk("b2b_results", 32'(nr), 4);
      chk("b2b_accepts", 32'(na), 4);
      for (int i = 0; i < 4; i++) chk("b2b_count", 32'(got[i]), 32'(be[i]));
      for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), W + 4);

      step();
      chk("det_x_outside_shift", 32'(detx_viol), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
